// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_pkg
//  Description : Shared defaults, counter-width helper and per-channel event
//                bundle for the push-button conditioning blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

    // Default configuration shared with other key consumers
    localparam int KEY_NUM_KEYS_DEF   = 4;
    localparam int KEY_TICK_DIV_DEF   = 4096;
    localparam int KEY_STABLE_DEF     = 5;
    localparam int KEY_LONG_DEF       = 256;
    localparam bit KEY_ACTIVE_LOW_DEF = 1'b1;

    // Bits needed to hold values 0..n-1, never less than one bit
    function automatic int CNT_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // One-cycle strobes produced by a channel
    typedef struct packed {
        logic press;
        logic rel;
        logic lng;
    } key_evt_t;

endpackage : key_pkg
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_ch
//  Description : One key channel: 2-flop synchroniser, consecutive-tick vote,
//                press/release strobes and long-press detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int STABLE_SAMPLES = KEY_STABLE_DEF,
    parameter int LONG_TICKS     = KEY_LONG_DEF,
    parameter bit ACTIVE_LOW     = KEY_ACTIVE_LOW_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     tick_i,
    input  logic     key_i,
    output logic     pressed_o,
    output key_evt_t evt_o
);

    localparam int STAB_W = CNT_W(STABLE_SAMPLES);
    localparam int HOLD_W = CNT_W(LONG_TICKS + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_SAMPLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);

    logic [1:0]        sync_q;
    logic              sync_p;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              pressed_q, pressed_d;
    key_evt_t          evt_q, evt_d;

    // Synchroniser resets to the idle pin level so reset looks like "released"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {2{ACTIVE_LOW}};
        else        sync_q <= {sync_q[0], key_i};
    end

    // Normalise after synchronisation: 1 means pressed
    assign sync_p = sync_q[1] ^ ACTIVE_LOW;

    // Vote on tick cycles, long-press counting and strobe generation
    always_comb begin
        stab_d    = stab_q;
        pressed_d = pressed_q;
        if (tick_i) begin
            if (sync_p == pressed_q) begin
                stab_d = '0;
            end else if (stab_q == STAB_LAST) begin
                pressed_d = sync_p;
                stab_d    = '0;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end

        // The acceptance tick itself is excluded because pressed_q is still 0
        if (!pressed_d)
            hold_d = '0;
        else if (tick_i && pressed_q && (hold_q != HOLD_MAX))
            hold_d = hold_q + 1'b1;
        else
            hold_d = hold_q;

        evt_d.press = pressed_d & ~pressed_q;
        evt_d.rel   = ~pressed_d & pressed_q;
        evt_d.lng   = (hold_d == HOLD_MAX) && (hold_q != HOLD_MAX);
    end

    // State and registered strobes; strobes appear with the new level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_q    <= '0;
            hold_q    <= '0;
            pressed_q <= 1'b0;
            evt_q     <= '0;
        end else begin
            stab_q    <= stab_d;
            hold_q    <= hold_d;
            pressed_q <= pressed_d;
            evt_q     <= evt_d;
        end
    end

    assign pressed_o = pressed_q;
    assign evt_o     = evt_q;

endmodule : key_debounce_ch
`default_nettype wire

// File: rtl/key_debounce_array.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_array
//  Description : Multi-channel key conditioner: shared sample-tick generator
//                feeding NUM_KEYS independent debounce channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_array
    import key_pkg::*;
#(
    parameter int NUM_KEYS       = KEY_NUM_KEYS_DEF,
    parameter int TICK_DIV       = KEY_TICK_DIV_DEF,
    parameter int STABLE_SAMPLES = KEY_STABLE_DEF,
    parameter int LONG_TICKS     = KEY_LONG_DEF,
    parameter bit ACTIVE_LOW     = KEY_ACTIVE_LOW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_pressed,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_pulse
);

    localparam int TICK_W = CNT_W(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick;

    assign tick = (tick_cnt_q == TICK_LAST);

    // Free-running sample divider, wraps after TICK_DIV cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    tick_cnt_q <= '0;
        else if (tick) tick_cnt_q <= '0;
        else           tick_cnt_q <= tick_cnt_q + 1'b1;
    end

    generate
        for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
            key_evt_t evt;

            key_debounce_ch #(
                .STABLE_SAMPLES (STABLE_SAMPLES),
                .LONG_TICKS     (LONG_TICKS),
                .ACTIVE_LOW     (ACTIVE_LOW)
            ) u_ch (
                .clk       (clk),
                .rst_n     (rst_n),
                .tick_i    (tick),
                .key_i     (key_in[i]),
                .pressed_o (key_pressed[i]),
                .evt_o     (evt)
            );

            assign press_pulse[i]   = evt.press;
            assign release_pulse[i] = evt.rel;
            assign long_pulse[i]    = evt.lng;
        end
    endgenerate

endmodule : key_debounce_array
`default_nettype wire

// File: tb/tb_key_debounce_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_debounce_array
//  Description : Directed self-checking bench with a strobe scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce_array;

    localparam int NK = 2;
    localparam int TD = 4;
    localparam int SS = 3;
    localparam int LT = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key_in = '1;
    logic [NK-1:0] key_pressed;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;
    logic [NK-1:0] long_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected strobe events, packed as {press[1:0], release[1:0], long[1:0]}
    logic [5:0] exp_q[$];
    logic [5:0] mon_obs;
    logic [5:0] mon_exp;

    key_debounce_array #(
        .NUM_KEYS       (NK),
        .TICK_DIV       (TD),
        .STABLE_SAMPLES (SS),
        .LONG_TICKS     (LT),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_in        (key_in),
        .key_pressed   (key_pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_win(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Wait for a strobe bit (sel 0=press 1=release 2=long); n = cycles taken
    task automatic wait_for(input int sel, input int bitn, input int maxc,
                            input string tag, output int n);
        logic [NK-1:0] v;
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(posedge clk); #1;
            v = (sel == 0) ? press_pulse : (sel == 1) ? release_pulse : long_pulse;
            if (v[bitn]) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: observed no strobe expected one within %0d cycles", tag, maxc);
        end
    endtask

    // Scoreboard: every strobe cycle must match the next expected event
    always @(posedge clk) begin
        #1;
        if (rst_n && ((press_pulse | release_pulse | long_pulse) != '0)) begin
            mon_obs = {press_pulse, release_pulse, long_pulse};
            if (exp_q.size() == 0) mon_exp = 6'h00;
            else                   mon_exp = exp_q.pop_front();
            chk("strobe_event", 32'(mon_obs), 32'(mon_exp));
        end
    end

    initial begin
        int n;

        // Reset state
        rst_n  = 1'b0;
        key_in = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_key_pressed", 32'(key_pressed), 32'h0);
        chk("reset_press_pulse", 32'(press_pulse), 32'h0);
        chk("reset_release_pulse", 32'(release_pulse), 32'h0);
        chk("reset_long_pulse", 32'(long_pulse), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk("idle_level", 32'(key_pressed), 32'h0);

        // Clean press and release on channel 0
        @(negedge clk);
        exp_q.push_back({2'b01, 2'b00, 2'b00});
        key_in[0] = 1'b0;
        wait_for(0, 0, 30, "clean_press", n);
        chk_win("clean_press_latency", n, 11, 14);
        chk("clean_press_level", 32'(key_pressed), 32'h1);
        @(posedge clk);
        #1 chk("press_pulse_width", 32'(press_pulse), 32'h0);
        @(negedge clk);
        exp_q.push_back({2'b00, 2'b01, 2'b00});
        key_in[0] = 1'b1;
        wait_for(1, 0, 30, "clean_release", n);
        chk_win("clean_release_latency", n, 11, 14);
        chk("clean_release_level", 32'(key_pressed), 32'h0);

        // Bounce: low 2 ticks, high 1, low 2, then high
        @(negedge clk) key_in[0] = 1'b0;
        repeat (8) @(negedge clk);
        key_in[0] = 1'b1;
        repeat (4) @(negedge clk);
        key_in[0] = 1'b0;
        repeat (8) @(negedge clk);
        chk("bounce_mid_level", 32'(key_pressed), 32'h0);
        key_in[0] = 1'b1;
        repeat (30) @(posedge clk);
        #1 chk("bounce_level", 32'(key_pressed), 32'h0);

        // Long press on channel 1
        @(negedge clk);
        exp_q.push_back({2'b10, 2'b00, 2'b00});
        key_in[1] = 1'b0;
        wait_for(0, 1, 30, "long_press_start", n);
        chk_win("long_press_latency", n, 11, 14);
        exp_q.push_back({2'b00, 2'b00, 2'b10});
        wait_for(2, 1, 60, "long_pulse", n);
        chk("long_pulse_delay", 32'(n), 32'd32);
        chk("long_level", 32'(key_pressed), 32'h2);
        repeat (16) @(posedge clk);
        @(negedge clk);
        exp_q.push_back({2'b00, 2'b10, 2'b00});
        key_in[1] = 1'b1;
        wait_for(1, 1, 30, "long_release", n);
        chk_win("long_release_latency", n, 11, 14);
        chk("long_release_level", 32'(key_pressed), 32'h0);

        // Simultaneous press and release of both channels
        @(negedge clk);
        exp_q.push_back({2'b11, 2'b00, 2'b00});
        key_in = 2'b00;
        wait_for(0, 0, 30, "sim_press", n);
        chk("sim_press_both", 32'(press_pulse), 32'h3);
        chk("sim_press_level", 32'(key_pressed), 32'h3);
        @(negedge clk);
        exp_q.push_back({2'b00, 2'b11, 2'b00});
        key_in = 2'b11;
        wait_for(1, 0, 30, "sim_release", n);
        chk("sim_release_both", 32'(release_pulse), 32'h3);

        // Reset while channel 0 is held and pressed
        @(negedge clk);
        exp_q.push_back({2'b01, 2'b00, 2'b00});
        key_in[0] = 1'b0;
        wait_for(0, 0, 30, "pre_reset_press", n);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_level", 32'(key_pressed), 32'h0);
        chk("mid_reset_strobes", 32'({press_pulse, release_pulse, long_pulse}), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back({2'b01, 2'b00, 2'b00});
        wait_for(0, 0, 30, "reset_repress", n);
        chk_win("reset_repress_latency", n, 11, 14);
        @(negedge clk);
        exp_q.push_back({2'b00, 2'b01, 2'b00});
        key_in[0] = 1'b1;
        wait_for(1, 0, 30, "final_release", n);

        repeat (5) @(posedge clk);
        #1 chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_key_debounce_array
`default_nettype wire
